// File: rtl/arb_pkg.sv
// Shared definitions for the write arbiter.
// Holds the FSM state width and the state encoding.
// The encoding is fixed: IDLE=0, GRANT=1, OUTPUT=2.
package arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search.
// Finds the first set request bit at or after the pointer, wrapping modulo NUM_WRITERS.
// The wrap works correctly even when NUM_WRITERS is not a power of two.
// Ports:
//   req_i  - per-writer request vector
//   ptr_i  - current round-robin pointer (highest-priority index)
//   any_o  - at least one request is set
//   idx_o  - index of the chosen writer (valid when any_o=1)
module rr_pick #(
  parameter int NUM_WRITERS = 4,
  parameter int ID_W        = $clog2(NUM_WRITERS)
) (
  input  logic [NUM_WRITERS-1:0] req_i,
  input  logic [ID_W-1:0]        ptr_i,
  output logic                   any_o,
  output logic [ID_W-1:0]        idx_o
);

  int cand;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int i = 0; i < NUM_WRITERS; i++) begin
      // Candidate index, wrapped modulo NUM_WRITERS rather than 2^ID_W.
      cand = int'(ptr_i) + i;
      if (cand >= NUM_WRITERS) cand = cand - NUM_WRITERS;
      if (!any_o && req_i[ID_W'(cand)]) begin
        any_o = 1'b1;
        idx_o = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/write_arbiter.sv
// Shares one downstream write sink between NUM_WRITERS req/busy writers.
//
// Handshake with the writers:
//   - A writer is granted when its busy bit is low for one cycle.
//   - The granted writer's data is captured into a one-entry output register.
//   - That register is presented to the sink with a valid/ready handshake.
//
// Priority is round-robin. The pointer advances only after a completed capture.
//
// Ports:
//   i_clk, i_reset_n  - clock; asynchronous active-low reset
//   i_req             - per-writer request
//   i_data            - per-writer data; writer k at [k*DATA_W +: DATA_W]
//   o_busy            - per-writer busy; a single low cycle is the grant
//   o_valid, o_data   - captured word towards the sink
//   o_id              - index of the writer that produced o_data
//   i_ready           - sink accepts when o_valid && i_ready at posedge
//   o_abort           - one-cycle pulse when the granted writer had dropped req
module write_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_WRITERS = 4,
  parameter  int DATA_W      = 8,
  localparam int ID_W        = $clog2(NUM_WRITERS)
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_WRITERS-1:0]        i_req,
  input  logic [NUM_WRITERS*DATA_W-1:0] i_data,
  output logic [NUM_WRITERS-1:0]        o_busy,
  output logic                          o_valid,
  output logic [DATA_W-1:0]             o_data,
  output logic [ID_W-1:0]               o_id,
  input  logic                          i_ready,
  output logic                          o_abort
);

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         ptr_q,   ptr_d;
  logic [ID_W-1:0]         gnt_q,   gnt_d;
  logic [NUM_WRITERS-1:0]  busy_q,  busy_d;
  logic                    valid_q, valid_d;
  logic [DATA_W-1:0]       data_q,  data_d;
  logic [ID_W-1:0]         id_q,    id_d;
  logic                    abort_q, abort_d;

  logic                    pick_any;
  logic [ID_W-1:0]         pick_idx;
  logic [DATA_W-1:0]       wr_data [NUM_WRITERS];

  rr_pick #(
    .NUM_WRITERS (NUM_WRITERS),
    .ID_W        (ID_W)
  ) u_pick (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_comb begin
    for (int k = 0; k < NUM_WRITERS; k++) begin
      wr_data[k] = i_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= '1;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    // Busy is low for one cycle at most, so it returns high unless a new grant is issued.
    busy_d  = '1;
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    abort_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          busy_d  = ~(NUM_WRITERS'(1) << pick_idx);
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (i_req[gnt_q]) begin
          data_d  = wr_data[gnt_q];
          id_d    = gnt_q;
          valid_d = 1'b1;
          ptr_d   = (gnt_q == ID_W'(NUM_WRITERS - 1)) ? '0 : gnt_q + 1'b1;
          state_d = ST_OUTPUT;
        end else begin
          // The writer withdrew before it saw the grant.
          // Keep the pointer unchanged so that this writer keeps its turn.
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_OUTPUT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_id    = id_q;
  assign o_abort = abort_q;

endmodule

// File: tb/tb_write_arbiter.sv
module tb_write_arbiter;

  logic        i_clk;
  logic        i_reset_n;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  o_busy;
  logic        o_valid;
  logic [7:0]  o_data;
  logic [1:0]  o_id;
  logic        i_ready;
  logic        o_abort;

  logic [7:0]  wd [4];
  int          total;
  int          bad;
  logic        prev_low;

  assign i_data = {wd[3], wd[2], wd[1], wd[0]};

  write_arbiter #(.NUM_WRITERS(4), .DATA_W(8)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_req     (i_req),
    .i_data    (i_data),
    .o_busy    (o_busy),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_id      (o_id),
    .i_ready   (i_ready),
    .o_abort   (o_abort)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Starting in IDLE with writer `id` expected to win:
  //   - grant edge
  //   - capture edge
  //   - accept edge, with i_ready held at 1
  task automatic serve(input int id, input logic [7:0] d, input bit drop);
    tick();
    chk("grant_busy", o_busy, 4'hF & ~(4'h1 << id));
    chk("grant_valid", o_valid, 0);
    tick();
    chk("out_valid", o_valid, 1);
    chk("out_data", o_data, d);
    chk("out_id", o_id, id);
    chk("out_busy", o_busy, 4'hF);
    if (drop) i_req[id] = 1'b0;
    tick();
    chk("accept_valid", o_valid, 0);
  endtask

  // Invariants, sampled on the falling edge
  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      prev_low = 1'b0;
    end else begin
      chk("inv_busy_onehot", ($countones(~o_busy) <= 1), 1);
      chk("inv_busy_vs_valid", (o_valid && o_busy != 4'hF), 0);
      chk("inv_busy_twice", (prev_low && o_busy != 4'hF), 0);
      prev_low = (o_busy != 4'hF);
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    prev_low  = 1'b0;
    i_reset_n = 1'b0;
    i_req     = 4'h0;
    i_ready   = 1'b1;
    for (int k = 0; k < 4; k++) wd[k] = 8'h00;

    // Reset state
    #12;
    chk("rst_busy", o_busy, 4'hF);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_id", o_id, 0);
    chk("rst_abort", o_abort, 0);
    i_reset_n = 1'b1;
    tick();
    chk("idle_busy", o_busy, 4'hF);

    // 1: single writer 1
    wd[1] = 8'h05;
    i_req = 4'b0010;
    serve(1, 8'h05, 1'b1);
    tick();
    chk("t1_idle_busy", o_busy, 4'hF);

    // Reset the pointer to 0 before the next test
    i_reset_n = 1'b0;
    #2;
    i_reset_n = 1'b1;

    // 2: all four request at once; expected order 0,1,2,3
    for (int k = 0; k < 4; k++) wd[k] = 8'h10 + 8'(k);
    i_req = 4'hF;
    for (int k = 0; k < 4; k++) serve(k, 8'h10 + 8'(k), 1'b1);

    // 3: writers 2 and 3 request continuously; pointer is 0, so 2,3,2,3
    wd[2] = 8'h22;
    wd[3] = 8'h33;
    i_req = 4'b1100;
    serve(2, 8'h22, 1'b0);
    serve(3, 8'h33, 1'b0);
    serve(2, 8'h22, 1'b0);
    serve(3, 8'h33, 1'b0);
    i_req = 4'h0;

    // 4: sink stalls for 5 cycles; pointer is 0
    wd[0]   = 8'hA5;
    i_req   = 4'b0001;
    i_ready = 1'b0;
    tick();
    chk("t4_grant_busy", o_busy, 4'b1110);
    tick();
    chk("t4_valid", o_valid, 1);
    i_req = 4'b0100;  // writer 0 done; writer 2 arrives and must wait
    wd[2] = 8'h5C;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4_hold_valid", o_valid, 1);
      chk("t4_hold_data", o_data, 8'hA5);
      chk("t4_hold_id", o_id, 0);
      chk("t4_hold_busy", o_busy, 4'hF);
    end
    i_ready = 1'b1;
    tick();
    chk("t4_accept", o_valid, 0);
    serve(2, 8'h5C, 1'b1);

    // 5: writer 0 withdraws in the GRANT cycle; pointer is 3
    wd[0] = 8'h77;
    i_req = 4'b0001;
    tick();
    chk("t5_grant_busy", o_busy, 4'b1110);
    i_req = 4'b0000;
    tick();
    chk("t5_abort", o_abort, 1);
    chk("t5_valid", o_valid, 0);
    chk("t5_busy", o_busy, 4'hF);
    tick();
    chk("t5_abort_end", o_abort, 0);
    chk("t5_valid2", o_valid, 0);
    // The pointer is still 3, so 0 beats 1
    wd[0] = 8'h78;
    wd[1] = 8'h79;
    i_req = 4'b0011;
    serve(0, 8'h78, 1'b1);
    serve(1, 8'h79, 1'b1);

    // 6: async reset while in OUTPUT; pointer is 2
    wd[2]   = 8'h66;
    i_req   = 4'b0100;
    i_ready = 1'b0;
    tick();
    chk("t6_grant_busy", o_busy, 4'b1011);
    tick();
    chk("t6_valid", o_valid, 1);
    chk("t6_id", o_id, 2);
    wd[0] = 8'h60;
    wd[1] = 8'h61;
    i_req = 4'b0111;
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_valid, 0);
    chk("t6_rst_busy", o_busy, 4'hF);
    chk("t6_rst_data", o_data, 0);
    #1;
    i_reset_n = 1'b1;
    i_ready   = 1'b1;
    serve(0, 8'h60, 1'b1);
    serve(1, 8'h61, 1'b1);
    serve(2, 8'h66, 1'b1);
    tick();
    chk("end_busy", o_busy, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
